// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg: shared definitions for the riscv_alu_mdu execute-stage unit.
//   - opcode encodings ALU_ADD..ALU_REMU
//   - FSM state enum (IDLE / MUL_RUN / DIV_RUN)
//   - opcode class helpers; is_iterative() follows RISCV_ALU_FAST_MUL_EN,
//     which turns the multiply ops into single-cycle ops when defined.
package riscv_alu_pkg;

   // Single-cycle integer ops
   localparam logic [4:0] ALU_ADD       = 5'd1;
   localparam logic [4:0] ALU_SUB       = 5'd2;
   localparam logic [4:0] ALU_AND       = 5'd3;
   localparam logic [4:0] ALU_OR        = 5'd4;
   localparam logic [4:0] ALU_XOR       = 5'd5;
   localparam logic [4:0] ALU_SLL       = 5'd6;
   localparam logic [4:0] ALU_SRL       = 5'd7;
   localparam logic [4:0] ALU_SRA       = 5'd8;
   localparam logic [4:0] ALU_SLT       = 5'd9;
   localparam logic [4:0] ALU_LUI       = 5'd10;
   localparam logic [4:0] ALU_SLTU      = 5'd11;
   localparam logic [4:0] ALU_BGE       = 5'd12;
   localparam logic [4:0] ALU_BGEU      = 5'd13;
   localparam logic [4:0] ALU_ADDPC     = 5'd14;
   localparam logic [4:0] ALU_JBADDRESS = 5'd15;
   localparam logic [4:0] ALU_BNE       = 5'd16;
   localparam logic [4:0] ALU_BLT       = 5'd17;
   localparam logic [4:0] ALU_BLTU      = 5'd18;
   // M-extension ops
   localparam logic [4:0] ALU_MUL       = 5'd19;
   localparam logic [4:0] ALU_MULH      = 5'd20;
   localparam logic [4:0] ALU_MULHSU    = 5'd21;
   localparam logic [4:0] ALU_MULHU     = 5'd22;
   localparam logic [4:0] ALU_DIV       = 5'd23;
   localparam logic [4:0] ALU_DIVU      = 5'd24;
   localparam logic [4:0] ALU_REM       = 5'd25;
   localparam logic [4:0] ALU_REMU      = 5'd26;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2
   } state_t;

   function automatic logic is_mul(input logic [4:0] op);
      return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

   // True for ops that run on the iterative engine.
   function automatic logic is_iterative(input logic [4:0] op);
`ifdef RISCV_ALU_FAST_MUL_EN
      return is_div(op);
`else
      return is_mul(op) || is_div(op);
`endif
   endfunction

endpackage

// File: rtl/riscv_mdu_iter.sv
// riscv_mdu_iter: iterative multiply / divide engine (one bit per cycle).
//   Shift-add multiply and restoring divide on operand magnitudes, with
//   the sign fix-up applied on the final iteration.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (clears the counter)
//   start         load operands and begin an XLEN-iteration run
//   op            M-extension opcode, sampled with start
//   src_a, src_b  operands, sampled with start
//   done          high during the final iteration; result is valid then
//   result        fixed-up result, meaningful only while done is high
module riscv_mdu_iter
   import riscv_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   logic [CW-1:0]     cnt_q;
   logic [4:0]        op_q;
   logic [XLEN-1:0]   mag_q;      // multiplicand (MUL) or divisor (DIV)
   logic [2*XLEN-1:0] acc_q;      // product, or {remainder, quotient}
   logic [2*XLEN-1:0] acc_nxt;
   logic              neg_q;      // sign of product / quotient
   logic              neg_rem_q;  // sign of remainder follows the dividend
   logic              b_zero_q;

   logic              sign_a, sign_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     sum, r_sh, diff;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo, rem;

   // Operand magnitudes per signedness of the requested op.
   always_comb begin
      sign_a = src_a[XLEN-1] && (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
      sign_b = src_b[XLEN-1] && (op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
      mag_a  = sign_a ? -src_a : src_a;
      mag_b  = sign_b ? -src_b : src_b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (start)
         cnt_q <= CW'(XLEN);
      else if (cnt_q != '0)
         cnt_q <= cnt_q - CW'(1);
   end

   // NOTE: datapath registers carry no reset; they are only observed while
   // cnt_q is non-zero, and cnt_q is reset.
   always_ff @(posedge clk) begin
      if (start) begin
         op_q      <= op;
         neg_q     <= sign_a ^ sign_b;
         neg_rem_q <= sign_a;
         b_zero_q  <= (src_b == '0);
         if (is_mul(op)) begin
            acc_q <= {{XLEN{1'b0}}, mag_b};
            mag_q <= mag_a;
         end else begin
            acc_q <= {{XLEN{1'b0}}, mag_a};
            mag_q <= mag_b;
         end
      end else if (cnt_q != '0) begin
         acc_q <= acc_nxt;
      end
   end

   // One iteration. Multiply: add multiplicand on LSB, shift right with the
   // carry. Divide: shift next dividend bit into the remainder, subtract
   // the divisor if it fits (borrow bit XLEN clear).
   always_comb begin
      sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
      r_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff = r_sh - {1'b0, mag_q};
      if (is_mul(op_q))
         acc_nxt = {sum, acc_q[XLEN-1:1]};
      else if (!diff[XLEN])
         acc_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         acc_nxt = {r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   // Sign fix-up on the value the final iteration produces. The signed
   // overflow case (most-negative / -1) falls out naturally; divide by
   // zero needs the all-ones quotient forced.
   always_comb begin
      prod_fix = neg_q ? -acc_nxt : acc_nxt;
      quo      = acc_nxt[XLEN-1:0];
      rem      = acc_nxt[2*XLEN-1:XLEN];
      result   = '0;
      case (op_q)
         ALU_MUL:                         result = prod_fix[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod_fix[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:               result = b_zero_q ? '1 : (neg_q ? -quo : quo);
         ALU_REM, ALU_REMU:               result = neg_rem_q ? -rem : rem;
         default:                         result = '0;
      endcase
   end

   assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/riscv_alu_mdu.sv
// riscv_alu_mdu: RV32I/RV64I ALU plus RV32M multiply/divide for the
// multi-cycle core's execute stage.
//   Single-cycle ops register their result on the accept edge; M ops run
//   XLEN iterations in riscv_mdu_iter behind the valid/ready handshake.
//   Build option RISCV_ALU_FAST_MUL_EN: multiplies become single-cycle.
// Ports:
//   clk        rising-edge clock
//   i_Rst_n    synchronous active-low reset
//   i_Valid    operation request (ignored while o_Ready is low)
//   o_Ready    request can be accepted (high in IDLE)
//   i_OpCode   operation select
//   i_SrcA/B   operands
//   o_Valid    one-cycle pulse, o_Result updated
//   o_Result   registered result, held until next o_Valid
//   o_Zero     o_Result == 0 (branch taken for branch opcodes)
//   o_Busy     iterative operation in flight
module riscv_alu_mdu
   import riscv_alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int OPW  = 5
) (
   input  logic            clk,
   input  logic            i_Rst_n,
   input  logic            i_Valid,
   output logic            o_Ready,
   input  logic [OPW-1:0]  i_OpCode,
   input  logic [XLEN-1:0] i_SrcA,
   input  logic [XLEN-1:0] i_SrcB,
   output logic            o_Valid,
   output logic [XLEN-1:0] o_Result,
   output logic            o_Zero,
   output logic            o_Busy
);

   localparam int SHW = $clog2(XLEN);

   state_t          state_q, state_d;
   logic [4:0]      op;
   logic            accept, mdu_start, mdu_done;
   logic [XLEN-1:0] mdu_result, alu_res, result_q;
   logic            valid_q;
   logic [SHW-1:0]  shamt;
   logic            lt_s, lt_u;

   assign op     = 5'(i_OpCode);
   assign accept = i_Valid && o_Ready;
   assign shamt  = i_SrcB[SHW-1:0];
   assign lt_s   = $signed(i_SrcA) < $signed(i_SrcB);
   assign lt_u   = i_SrcA < i_SrcB;

`ifdef RISCV_ALU_FAST_MUL_EN
   logic [2*XLEN-1:0] a_ext, b_ext, prod;
   always_comb begin
      a_ext = (op == ALU_MULHU) ? {{XLEN{1'b0}}, i_SrcA} : {{XLEN{i_SrcA[XLEN-1]}}, i_SrcA};
      b_ext = (op inside {ALU_MULHSU, ALU_MULHU}) ? {{XLEN{1'b0}}, i_SrcB}
                                                  : {{XLEN{i_SrcB[XLEN-1]}}, i_SrcB};
      prod  = a_ext * b_ext;
   end
`endif

   // Branch ops return 0 when taken so o_Zero doubles as the taken flag.
   always_comb begin
      // NOTE: default first so every path assigns alu_res and no latch is inferred.
      alu_res = '0;
      case (op)
         ALU_ADD:       alu_res = i_SrcA + i_SrcB;
         ALU_SUB:       alu_res = i_SrcA - i_SrcB;
         ALU_AND:       alu_res = i_SrcA & i_SrcB;
         ALU_OR:        alu_res = i_SrcA | i_SrcB;
         ALU_XOR:       alu_res = i_SrcA ^ i_SrcB;
         ALU_SLL:       alu_res = i_SrcA << shamt;
         ALU_SRL:       alu_res = i_SrcA >> shamt;
         ALU_SRA:       alu_res = $signed(i_SrcA) >>> shamt;
         ALU_SLT:       alu_res = XLEN'(lt_s);
         ALU_LUI:       alu_res = i_SrcB;
         ALU_SLTU:      alu_res = XLEN'(lt_u);
         ALU_BGE:       alu_res = XLEN'(lt_s);
         ALU_BGEU:      alu_res = XLEN'(lt_u);
         ALU_ADDPC:     alu_res = i_SrcA + XLEN'(4);
         ALU_JBADDRESS: alu_res = i_SrcA - XLEN'(4) + i_SrcB;
         ALU_BNE:       alu_res = XLEN'(i_SrcA == i_SrcB);
         ALU_BLT:       alu_res = XLEN'(!lt_s);
         ALU_BLTU:      alu_res = XLEN'(!lt_u);
`ifdef RISCV_ALU_FAST_MUL_EN
         ALU_MUL:       alu_res = prod[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU:
                        alu_res = prod[2*XLEN-1:XLEN];
`endif
         default:       alu_res = '0;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      if (!i_Rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:             if (accept && is_iterative(op))
                              state_d = is_mul(op) ? MUL_RUN : DIV_RUN;
         MUL_RUN, DIV_RUN: if (mdu_done)
                              state_d = IDLE;
         default:          state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_Ready   = (state_q == IDLE);
      o_Busy    = (state_q != IDLE);
      mdu_start = i_Valid && (state_q == IDLE) && is_iterative(op);
   end

   riscv_mdu_iter #(
      .XLEN (XLEN)
   ) u_mdu_iter (
      .clk    (clk),
      .rst_n  (i_Rst_n),
      .start  (mdu_start),
      .op     (op),
      .src_a  (i_SrcA),
      .src_b  (i_SrcB),
      .done   (mdu_done),
      .result (mdu_result)
   );

   // Output register: single-cycle results on accept, M results on done.
   always_ff @(posedge clk) begin
      if (!i_Rst_n) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (accept && !is_iterative(op)) begin
            result_q <= alu_res;
            valid_q  <= 1'b1;
         end else if (mdu_done) begin
            result_q <= mdu_result;
            valid_q  <= 1'b1;
         end
      end
   end

   assign o_Result = result_q;
   assign o_Valid  = valid_q;
   assign o_Zero   = (result_q == '0);

endmodule

// File: tb/tb_riscv_alu_mdu.sv
// tb_riscv_alu_mdu: directed-vector bench with a scoreboard queue.
// Stimulus pushes the hand-computed result on issue; a monitor pops and
// compares on every o_Valid. Timing checks for the iterative window and
// reset are made inline by the stimulus process.
module tb_riscv_alu_mdu;
   import riscv_alu_pkg::*;

   localparam int XLEN = 32;
   localparam int OPW  = 5;

   logic            clk = 1'b0;
   logic            i_Rst_n = 1'b0;
   logic            i_Valid = 1'b0;
   logic [OPW-1:0]  i_OpCode = '0;
   logic [XLEN-1:0] i_SrcA = '0;
   logic [XLEN-1:0] i_SrcB = '0;
   logic            o_Ready, o_Valid, o_Zero, o_Busy;
   logic [XLEN-1:0] o_Result;

   riscv_alu_mdu #(
      .XLEN (XLEN),
      .OPW  (OPW)
   ) dut (
      .clk      (clk),
      .i_Rst_n  (i_Rst_n),
      .i_Valid  (i_Valid),
      .o_Ready  (o_Ready),
      .i_OpCode (i_OpCode),
      .i_SrcA   (i_SrcA),
      .i_SrcB   (i_SrcB),
      .o_Valid  (o_Valid),
      .o_Result (o_Result),
      .o_Zero   (o_Zero),
      .o_Busy   (o_Busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [XLEN-1:0] res;
      string           name;
   } exp_t;
   exp_t sb_q[$];

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Monitor: every o_Valid must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_Valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_valid: o_Valid=1 result 0x%h, expected no output", o_Result);
            end else begin
               e = sb_q.pop_front();
               check(e.name, o_Result, e.res);
               check({e.name, "_zero"}, XLEN'(o_Zero), XLEN'(e.res == '0));
            end
         end
      end
   end

   // Drive a request at a negedge once o_Ready is high; i_Valid stays high
   // until the next call or idle().
   task automatic send(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input string name);
      int waited = 0;
      @(negedge clk);
      while (o_Ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (o_Ready !== 1'b1) check({name, "_ready_timeout"}, XLEN'(o_Ready), XLEN'(1));
      i_OpCode = OPW'(op);
      i_SrcA   = a;
      i_SrcB   = b;
      i_Valid  = 1'b1;
      sb_q.push_back('{exp, name});
   endtask

   task automatic idle();
      @(negedge clk);
      i_Valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int waited = 0;
      while (sb_q.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_drained"}, XLEN'(sb_q.size()), '0);
   endtask

`ifndef RISCV_ALU_FAST_MUL_EN
   // Iterative op with i_Valid held through the whole run: o_Ready low and
   // o_Busy high for XLEN cycles, result on the next cycle, one accept only.
   task automatic run_iter_timed(input logic [4:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                                 input string name);
      int bad = 0;
      send(op, a, b, exp, name);
      for (int i = 1; i <= XLEN; i++) begin
         @(negedge clk);
         if (o_Ready !== 1'b0 || o_Busy !== 1'b1 || o_Valid !== 1'b0) bad++;
      end
      check({name, "_busy_window_bad_cycles"}, XLEN'(bad), '0);
      @(negedge clk);
      check({name, "_valid_at_latency"}, XLEN'(o_Valid), XLEN'(1));
      check({name, "_ready_after"}, XLEN'(o_Ready), XLEN'(1));
      i_Valid = 1'b0;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      i_Rst_n = 1'b1;
      check("reset_result", o_Result, '0);
      check("reset_zero",   XLEN'(o_Zero),  XLEN'(1));
      check("reset_ready",  XLEN'(o_Ready), XLEN'(1));
      check("reset_valid",  XLEN'(o_Valid), '0);
      check("reset_busy",   XLEN'(o_Busy),  '0);

      // Back-to-back single-cycle ops: one result per cycle
      @(negedge clk);
      i_OpCode = OPW'(ALU_ADD); i_SrcA = 32'd5; i_SrcB = 32'd7; i_Valid = 1'b1;
      sb_q.push_back('{32'd12, "add_5_7"});
      @(negedge clk);
      check("b2b_valid_1", XLEN'(o_Valid), XLEN'(1));
      i_OpCode = OPW'(ALU_SUB); i_SrcA = 32'd3; i_SrcB = 32'd3;
      sb_q.push_back('{32'd0, "sub_3_3"});
      @(negedge clk);
      check("b2b_valid_2", XLEN'(o_Valid), XLEN'(1));
      i_OpCode = OPW'(ALU_SRA); i_SrcA = 32'h8000_0000; i_SrcB = 32'd4;
      sb_q.push_back('{32'hF800_0000, "sra_min_4"});
      @(negedge clk);
      check("b2b_valid_3", XLEN'(o_Valid), XLEN'(1));
      i_Valid = 1'b0;

      // Remaining single-cycle ops, branches, undefined opcodes
      send(ALU_AND,       32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, "and");
      send(ALU_OR,        32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, "or");
      send(ALU_XOR,       32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, "xor");
      send(ALU_SLL,       32'h0000_0001, 32'h0000_0021, 32'h0000_0002, "sll_shamt_masked");
      send(ALU_SRL,       32'h8000_0000, 32'd4,         32'h0800_0000, "srl");
      send(ALU_SLT,       32'hFFFF_FFFF, 32'd1,         32'd1,         "slt_neg");
      send(ALU_SLTU,      32'hFFFF_FFFF, 32'd1,         32'd0,         "sltu_big");
      send(ALU_LUI,       32'h1111_1111, 32'h1234_5000, 32'h1234_5000, "lui");
      send(ALU_ADDPC,     32'h0000_0100, 32'h0000_0000, 32'h0000_0104, "addpc");
      send(ALU_JBADDRESS, 32'h0000_0100, 32'h0000_0020, 32'h0000_011C, "jbaddress");
      send(ALU_BGE,       32'd5,         32'd5,         32'd0,         "bge_equal_taken");
      send(ALU_BGE,       32'd4,         32'd5,         32'd1,         "bge_not_taken");
      send(ALU_BGEU,      32'hFFFF_FFFF, 32'd1,         32'd0,         "bgeu_taken");
      send(ALU_BLTU,      32'd1,         32'hFFFF_FFFF, 32'd0,         "bltu_taken");
      send(ALU_BNE,       32'd4,         32'd4,         32'd1,         "bne_not_taken");
      send(ALU_BLT,       32'hFFFF_FFFF, 32'd0,         32'd0,         "blt_taken");
      send(5'd0,          32'd9,         32'd9,         32'd0,         "undef_op0");
      send(5'd31,         32'd9,         32'd9,         32'd0,         "undef_op31");
      idle();
      drain("single_cycle");

`ifndef RISCV_ALU_FAST_MUL_EN
      // Iterative latency / held-valid checks
      run_iter_timed(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
      run_iter_timed(ALU_MUL,  32'd6,         32'd7,         32'd42,        "mul_held_valid");
      drain("iter_timed");
`else
      // Fast multiply: result in the cycle after accept, never busy
      send(ALU_MUL, 32'd6, 32'd7, 32'd42, "fast_mul_6_7");
      @(negedge clk);
      check("fast_mul_valid_next_cycle", XLEN'(o_Valid), XLEN'(1));
      check("fast_mul_busy", XLEN'(o_Busy), '0);
      check("fast_mul_ready", XLEN'(o_Ready), XLEN'(1));
      i_Valid = 1'b0;
      send(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
      idle();
      drain("fast_mul");
`endif

      // Multiply / divide results
      send(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max");
      send(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max_max");
      send(ALU_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, "mul_m3_5");
      send(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
      send(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow");
      send(ALU_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, "divu_by_zero");
      send(ALU_REMU,   32'd7,         32'd0,         32'd7,         "remu_by_zero");
      send(ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
      send(ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
      send(ALU_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "div_m7_by_zero");
      send(ALU_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_m7_by_zero");
      send(ALU_DIVU,   32'd100,       32'd7,         32'd14,        "divu_100_7");
      send(ALU_REMU,   32'd100,       32'd7,         32'd2,         "remu_100_7");
      idle();
      drain("mdu");

      // Reset during a DIV (iteration 10 of 32): op aborted, no late result
      @(negedge clk);
      i_OpCode = OPW'(ALU_DIV); i_SrcA = 32'd100; i_SrcB = 32'd7; i_Valid = 1'b1;
      @(negedge clk);
      i_Valid = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_reset_busy", XLEN'(o_Busy), XLEN'(1));
      i_Rst_n = 1'b0;
      @(negedge clk);
      i_Rst_n = 1'b1;
      check("midrst_result", o_Result, '0);
      check("midrst_zero",   XLEN'(o_Zero),  XLEN'(1));
      check("midrst_ready",  XLEN'(o_Ready), XLEN'(1));
      check("midrst_valid",  XLEN'(o_Valid), '0);
      check("midrst_busy",   XLEN'(o_Busy),  '0);
      repeat (40) @(negedge clk);

      // Recovery after the abort
      send(ALU_ADD, 32'd1, 32'd2, 32'd3, "add_after_reset");
      idle();
      drain("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_alu_mdu.md
Name: riscv_alu_mdu

Overview:
- Parametrised successor ALU: the full RV32I integer op set plus the RV32M multiply/divide/remainder ops, with XLEN-bit datapath.
- Single-cycle ops have a 1-cycle registered latency.
- M-extension ops run iteratively (shift-add multiply, restoring divide) behind a valid/ready handshake.
- Sits in the multi-cycle core's execute stage; the control FSM waits on o_Valid.

Parameters:
- XLEN, 32, datapath width in bits; legal values 32 or 64.
- OPW, 5, opcode width.

Ports:
- clk  in  1  rising-edge clock.
- i_Rst_n  in  1  synchronous active-low reset.
- i_Valid  in  1  operation request.
- o_Ready  out  1  block can accept a request; combinational, high in IDLE.
- i_OpCode  in  OPW  operation select.
- i_SrcA  in  XLEN  operand A, signed view.
- i_SrcB  in  XLEN  operand B, signed view.
- o_Valid  out  1  one-cycle pulse; o_Result is new this cycle.
- o_Result  out  XLEN  registered result; holds until the next o_Valid.
- o_Zero  out  1  (o_Result == 0); derived from the register.
- o_Busy  out  1  iterative operation in flight.

Behaviour:
- Reset (i_Rst_n=0 at a clk edge) takes effect from any state, including mid-iteration. It aborts the op and forces state IDLE, o_Result=0, o_Zero=1, o_Valid=0, o_Busy=0, iteration counter=0. o_Ready=1 after the reset edge.
- Accept: i_Valid && o_Ready at edge N. Operands and opcode are latched. i_Valid is ignored while o_Ready=0.
- Single-cycle opcodes 1..18, with the same codes and meaning as the existing ALU:
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 LUI (pass B), 11 SLTU.
  - 12 BGE, 13 BGEU, 16 BNE, 17 BLT, 18 BLTU.
  - 14 ADDPC (A+4), 15 JBADDRESS (A-4+B).
  - Result is registered at edge N+1; o_Valid=1 in cycle N+1; state stays IDLE, so back-to-back accepts give one result per cycle.
- Shift amount is B[$clog2(XLEN)-1:0].
- Branch codes return 0 when the branch is taken, so o_Zero=1 means taken. BGE is taken on A>=B (signed); BGEU on A>=B (unsigned). Equality counts as taken.
- Iterative opcodes: 19 MUL, 20 MULH, 21 MULHSU, 22 MULHU, 23 DIV, 24 DIVU, 25 REM, 26 REMU.
  - States: IDLE -> MUL_RUN or DIV_RUN -> IDLE.
  - On accept: operands are converted to magnitudes per signedness, the result sign is recorded, and the counter is loaded with XLEN.
  - One iteration per cycle; o_Busy=1 and o_Ready=0 in cycles N+1..N+XLEN.
  - The final iteration applies the sign fix-up and registers the result: o_Valid=1 in cycle N+XLEN+1. State returns to IDLE at the same edge, so a new accept is legal in cycle N+XLEN+1.
  - Latency is XLEN+1 cycles.
- MUL returns low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU return the high XLEN bits with signed×signed / signed×unsigned / unsigned×unsigned operands.
- Divide by zero (no trap):
  - DIV/DIVU give all ones.
  - REM/REMU give the dividend.
- Signed overflow (A = most negative, B = -1):
  - DIV gives A.
  - REM gives 0.
- Undefined opcodes (0, 27..31) give result 0 with 1-cycle latency.
- o_Valid is never asserted in the same cycle as reset.

Optional Feature:
- Macro RISCV_ALU_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU are computed with a single-cycle 2*XLEN product and are treated as single-cycle ops (latency 1, no MUL_RUN state).
  - Divide ops are unchanged.
- Undefined: iterative multiply as specified above.

Decomposition:
- Package riscv_alu_pkg holds:
  - opcode localparams ALU_ADD..ALU_REMU;
  - the state enum (IDLE, MUL_RUN, DIV_RUN);
  - an is_iterative(op) helper function.
- One natural sub-module: riscv_mdu_iter, the shared iterative engine containing the magnitude registers, counter, partial product/remainder and sign fix-up, with start/done strobes. The top holds the single-cycle ALU, output register and handshake.

Test Plan:
- Reset mid-DIV (cycle 10 of 32) -> cycle after reset: o_Result=0, o_Zero=1, o_Ready=1, o_Valid=0; no late o_Valid.
- Back-to-back ADD 5+7, SUB 3-3, SRA 0x80000000>>>4 -> o_Valid three consecutive cycles; results 12, 0 (o_Zero=1), 0xF8000000.
- MULH 0x80000000×0x80000000 accepted at N -> o_Ready=0 for N+1..N+32; o_Valid at N+33 with 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
- BGE 5,5 -> result 0, o_Zero=1. BLTU 1,0xFFFFFFFF -> 0. BNE 4,4 -> 1. i_Valid held during a MUL -> exactly one accept.
- With RISCV_ALU_FAST_MUL_EN: MUL 6×7 -> 42 in cycle N+1; o_Busy never asserts.
